// File: rtl/seg_scan_pkg.sv
// Shared glyph constants, FSM state encodings and decoded-digit bundle
// for the scanned 7-segment receive path.
package seg_scan_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h7E;
  localparam logic [6:0] GLYPH_1     = 7'h30;
  localparam logic [6:0] GLYPH_2     = 7'h6D;
  localparam logic [6:0] GLYPH_3     = 7'h79;
  localparam logic [6:0] GLYPH_4     = 7'h33;
  localparam logic [6:0] GLYPH_5     = 7'h5B;
  localparam logic [6:0] GLYPH_6     = 7'h5F;
  localparam logic [6:0] GLYPH_7     = 7'h70;
  localparam logic [6:0] GLYPH_7ALT  = 7'h72;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h7B;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h1F;
  localparam logic [6:0] GLYPH_C     = 7'h4E;
  localparam logic [6:0] GLYPH_D     = 7'h3D;
  localparam logic [6:0] GLYPH_E     = 7'h4F;
  localparam logic [6:0] GLYPH_F     = 7'h47;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_TRACK,
    CAP_HOLD
  } cap_state_e;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] value;
  } digit_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational segment pattern -> digit decoder.
// Define SEG_HEX_EN to also accept the A..F hex glyphs.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output digit_t     dig_o
);

  always_comb begin
    dig_o = '{err: 1'b0, blank: 1'b0, value: 4'h0};
    case (seg_i)
      GLYPH_0:     dig_o.value = 4'h0;
      GLYPH_1:     dig_o.value = 4'h1;
      GLYPH_2:     dig_o.value = 4'h2;
      GLYPH_3:     dig_o.value = 4'h3;
      GLYPH_4:     dig_o.value = 4'h4;
      GLYPH_5:     dig_o.value = 4'h5;
      GLYPH_6:     dig_o.value = 4'h6;
      GLYPH_7:     dig_o.value = 4'h7;
      GLYPH_7ALT:  dig_o.value = 4'h7;
      GLYPH_8:     dig_o.value = 4'h8;
      GLYPH_9:     dig_o.value = 4'h9;
      GLYPH_BLANK: dig_o.blank = 1'b1;
`ifdef SEG_HEX_EN
      GLYPH_A:     dig_o.value = 4'hA;
      GLYPH_B:     dig_o.value = 4'hB;
      GLYPH_C:     dig_o.value = 4'hC;
      GLYPH_D:     dig_o.value = 4'hD;
      GLYPH_E:     dig_o.value = 4'hE;
      GLYPH_F:     dig_o.value = 4'hF;
`endif
      default: begin
        dig_o.err   = 1'b1;
        dig_o.value = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a scanned 7-segment bus and delivers whole decoded frames
// over valid/ready. Hex glyphs depend on SEG_HEX_EN in seg_glyph_decode.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int STABLE_CNT  = 3,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   out_value,
  output logic [DIGITS-1:0]     out_blank,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [6:0]        seg_q, seg_prev_q;
  logic [DIGITS-1:0] sel_q, sel_prev_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  cap_state_e        cap_q, cap_d;
  out_state_e        out_q, out_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  digit_t            stage_q [DIGITS];
  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0] blank_q, err_q;
  logic              ovr_q, ovr_d;
  logic              onehot, same, latch, complete, load;
  digit_t            dec;

  seg_glyph_decode u_dec (
    .seg_i (seg_q),
    .dig_o (dec)
  );

  assign onehot = (sel_q != '0) &&
                  ((sel_q & (sel_q - DIGITS'(1))) == '0);
  assign same   = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
  assign complete = &mask_q;

  always_comb begin
    cap_d = cap_q;
    cnt_d = cnt_q;
    latch = 1'b0;
    if (!onehot) begin
      cap_d = CAP_IDLE;
      cnt_d = '0;
    end else if (!(cap_q == CAP_HOLD && same)) begin
      cnt_d = (cap_q == CAP_TRACK && same) ? cnt_q + 1'b1 : CW'(1);
      if (cnt_d == CW'(STABLE_CNT)) begin
        latch = 1'b1;
        cap_d = CAP_HOLD;
      end else begin
        cap_d = CAP_TRACK;
      end
    end
  end

  // A completing frame frees the mask, but a digit latched the same cycle
  // already belongs to the next frame.
  assign mask_d = (complete ? '0 : mask_q) | (latch ? sel_q : '0);

  always_comb begin
    out_d = out_q;
    ovr_d = ovr_q;
    load  = 1'b0;
    if (complete) begin
      if (out_q == OUT_EMPTY || out_ready) begin
        load  = 1'b1;
        out_d = OUT_FULL;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (out_q == OUT_FULL && out_ready) begin
      out_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      cap_q      <= CAP_IDLE;
      out_q      <= OUT_EMPTY;
      mask_q     <= '0;
      val_q      <= '0;
      blank_q    <= '0;
      err_q      <= '0;
      ovr_q      <= 1'b0;
      for (int k = 0; k < DIGITS; k++) stage_q[k] <= '0;
    end else begin
      seg_q      <= (SEG_ACT_LOW != 0) ? ~seg_in : seg_in;
      sel_q      <= dig_sel;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      out_q      <= out_d;
      mask_q     <= mask_d;
      ovr_q      <= ovr_d;
      for (int k = 0; k < DIGITS; k++) begin
        if (latch && sel_q[k]) stage_q[k] <= dec;
        if (load) begin
          val_q[4*k +: 4] <= stage_q[k].value;
          blank_q[k]      <= stage_q[k].blank;
          err_q[k]        <= stage_q[k].err;
        end
      end
    end
  end

  assign out_value = val_q;
  assign out_blank = blank_q;
  assign out_err   = err_q;
  assign out_valid = (out_q == OUT_FULL);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (DIGITS=4, STABLE_CNT=3).
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] out_value;
  logic [3:0]  out_blank, out_err;
  logic        out_valid, out_ready = 1'b0, overrun;
  int          checks = 0;
  int          errors = 0;

  seg_scan_decoder #(
    .DIGITS(4), .STABLE_CNT(3), .SEG_ACT_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .out_value(out_value), .out_blank(out_blank), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // called at a negedge; holds the bus for n rising edges
  task automatic show(input logic [3:0] sel, input logic [6:0] pat,
                      input int n);
    seg_in  = pat;
    dig_sel = sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_value, out_blank, out_err, out_valid, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h/%b/%b/%b/%b exp 0",
               out_value, out_blank, out_err, out_valid, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    show(4'b0001, 7'h30, 4);
    show(4'b0010, 7'h6D, 4);
    show(4'b0100, 7'h79, 4);
    show(4'b1000, 7'h33, 4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_early_valid got %b exp 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL t1_valid got %b exp 1", out_valid);
    end
    checks++;
    if (out_value !== 16'h4321 || out_err !== 4'b0 || out_blank !== 4'b0) begin
      errors++;
      $display("FAIL t1_value got %h err %b blank %b exp 4321 0 0",
               out_value, out_err, out_blank);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_consume got %b exp 0", out_valid);
    end
  endtask

  task automatic test_unstable();
    show(4'b0001, 7'h30, 4);
    show(4'b0100, 7'h79, 4);
    show(4'b1000, 7'h33, 4);
    for (int i = 0; i < 4; i++) begin
      show(4'b0010, 7'h5B, 2);
      show(4'b0010, 7'h7E, 2);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t2_no_latch got valid %b exp 0", out_valid);
    end
    show(4'b0010, 7'h6D, 4);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h4321) begin
      errors++;
      $display("FAIL t2_final got %b %h exp 1 4321", out_valid, out_value);
    end
    consume();
  endtask

  task automatic test_overrun();
    show(4'b0001, 7'h7B, 4);
    show(4'b0010, 7'h7E, 4);
    show(4'b0100, 7'h72, 4);
    show(4'b1000, 7'h7F, 4);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h8709 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t3_first got %b %h ovr %b exp 1 8709 0",
               out_valid, out_value, overrun);
    end
    show(4'b0001, 7'h5B, 4);
    show(4'b0010, 7'h5F, 4);
    show(4'b0100, 7'h70, 4);
    show(4'b1000, 7'h30, 4);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h8709 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL t3_held got %b %h ovr %b exp 1 8709 1",
               out_valid, out_value, overrun);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_drop got %b exp 0", out_valid);
    end
  endtask

  task automatic test_hex_blank();
    logic [15:0] exp_v;
    logic [3:0]  exp_e;
`ifdef SEG_HEX_EN
    exp_v = 16'h4A20;
    exp_e = 4'b0000;
`else
    exp_v = 16'h4F20;
    exp_e = 4'b0100;
`endif
    show(4'b0001, 7'h00, 4);
    show(4'b0010, 7'h6D, 4);
    show(4'b0100, 7'h77, 4);
    show(4'b1000, 7'h33, 4);
    @(negedge clk);
    checks++;
    if (out_value !== exp_v || out_err !== exp_e) begin
      errors++;
      $display("FAIL t4_hex got %h err %b exp %h %b",
               out_value, out_err, exp_v, exp_e);
    end
    checks++;
    if (out_blank !== 4'b0001) begin
      errors++;
      $display("FAIL t4_blank got %b exp 0001", out_blank);
    end
    consume();
  endtask

  task automatic test_bad_sel();
    show(4'b0001, 7'h5F, 4);
    show(4'b0010, 7'h7B, 4);
    show(4'b0011, 7'h7F, 10);
    show(4'b0000, 7'h7F, 10);
    show(4'b0100, 7'h79, 4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_early got valid %b exp 0", out_valid);
    end
    show(4'b1000, 7'h5B, 4);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h5396) begin
      errors++;
      $display("FAIL t5_frame got %b %h exp 1 5396", out_valid, out_value);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    show(4'b0001, 7'h30, 4);
    show(4'b0010, 7'h6D, 4);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL t6_sticky got ovr %b exp 1", overrun);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_value, out_valid, overrun} !== '0) begin
      errors++;
      $display("FAIL t6_rst got %h %b %b exp 0", out_value, out_valid, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    show(4'b0100, 7'h79, 4);
    show(4'b1000, 7'h33, 4);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_partial got valid %b exp 0", out_valid);
    end
    show(4'b0001, 7'h30, 4);
    show(4'b0010, 7'h6D, 4);
    show(4'b0100, 7'h79, 4);
    show(4'b1000, 7'h33, 4);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h4321) begin
      errors++;
      $display("FAIL t6_full got %b %h exp 1 4321", out_valid, out_value);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_unstable();
    test_overrun();
    test_hex_blank();
    test_bad_sel();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
